// File: rtl/cla_pkg.sv
// Shared carry-lookahead types and helpers for the CLA adder family.
// Holds the (G,P) pair type, its composition operator and parameter checks.
package cla_pkg;

    localparam int unsigned CLA_GROUP_W = 4;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    localparam gp_t GP_IDENT = '{g: 1'b0, p: 1'b1};

    // Compose a more-significant (hi) span with a less-significant (lo) span.
    function automatic gp_t gp_merge(input gp_t hi, input gp_t lo);
        gp_t r;
        r.g = hi.g | (hi.p & lo.g);
        r.p = hi.p & lo.p;
        return r;
    endfunction

    function automatic bit cla_cfg_ok(input int unsigned width, input int unsigned seg_w);
        return (width != 0) && (seg_w != 0) && (seg_w % CLA_GROUP_W == 0) && (width % seg_w == 0);
    endfunction

endpackage

// File: rtl/cla_segment.sv
// Combinational SEG_W-bit carry-lookahead segment built from 4-bit groups.
// Group (G,P) prefixes give each group's carry-in; bit carries come from in-group prefixes.
module cla_segment
    import cla_pkg::*;
#(
    parameter int unsigned SEG_W = 8
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    localparam int unsigned NGRP = SEG_W / CLA_GROUP_W;

    logic [SEG_W-1:0] g;
    logic [SEG_W-1:0] p;
    logic [SEG_W:0]   c;
    gp_t              pre;
    gp_t              lp;
    logic             cg;

    always_comb begin
        g   = a & b;
        p   = a ^ b;
        c   = '0;
        pre = GP_IDENT;
        lp  = GP_IDENT;
        cg  = 1'b0;
        for (int unsigned j = 0; j < NGRP; j++) begin
            cg = pre.g | (pre.p & cin);
            lp = GP_IDENT;
            for (int unsigned i = 0; i < CLA_GROUP_W; i++) begin
                c[j*CLA_GROUP_W + i] = lp.g | (lp.p & cg);
                lp = gp_merge('{g: g[j*CLA_GROUP_W + i], p: p[j*CLA_GROUP_W + i]}, lp);
            end
            pre = gp_merge(lp, pre);
        end
        c[SEG_W] = pre.g | (pre.p & cin);
    end

    assign sum   = p ^ c[SEG_W-1:0];
    assign cout  = c[SEG_W];
    assign c_msb = c[SEG_W-1];

endmodule

// File: rtl/cla_pipelined_addsub.sv
// Pipelined add/subtract: one CLA segment resolved per stage, carry registered between stages.
// Valid/ready streaming with whole-pipeline stall on output backpressure.
module cla_pipelined_addsub
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NSEG = WIDTH / SEG_W;

    if (!cla_cfg_ok(WIDTH, SEG_W)) begin : g_bad_cfg
        $error("cla_pipelined_addsub: WIDTH must be a multiple of SEG_W, SEG_W a multiple of 4");
    end

    logic             valid_q [NSEG];
    logic             valid_d [NSEG];
    logic [WIDTH-1:0] a_q     [NSEG];
    logic [WIDTH-1:0] a_d     [NSEG];
    logic [WIDTH-1:0] b_q     [NSEG];
    logic [WIDTH-1:0] b_d     [NSEG];
    logic [WIDTH-1:0] sum_q   [NSEG];
    logic [WIDTH-1:0] sum_d   [NSEG];
    logic             carry_q [NSEG];
    logic             carry_d [NSEG];
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             stall;
    logic [WIDTH-1:0] b_in;

    logic [SEG_W-1:0] seg_a    [NSEG];
    logic [SEG_W-1:0] seg_b    [NSEG];
    logic             seg_cin  [NSEG];
    logic [SEG_W-1:0] seg_sum  [NSEG];
    logic             seg_cout [NSEG];
    logic             seg_cmsb [NSEG];

    assign b_in = sub ? ~B : B;

    // Stage 0 reads the ports directly; later stages read the previous stage register.
    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        if (k == 0) begin : g_first
            assign seg_a[k]   = A[SEG_W-1:0];
            assign seg_b[k]   = b_in[SEG_W-1:0];
            assign seg_cin[k] = Cin;
        end else begin : g_next
            assign seg_a[k]   = a_q[k-1][k*SEG_W +: SEG_W];
            assign seg_b[k]   = b_q[k-1][k*SEG_W +: SEG_W];
            assign seg_cin[k] = carry_q[k-1];
        end

        cla_segment #(.SEG_W(SEG_W)) u_seg (
            .a     (seg_a[k]),
            .b     (seg_b[k]),
            .cin   (seg_cin[k]),
            .sum   (seg_sum[k]),
            .cout  (seg_cout[k]),
            .c_msb (seg_cmsb[k])
        );
    end

    always_comb begin
        stall = valid_q[NSEG-1] && !out_ready;

        valid_d[0] = in_valid;
        a_d[0]     = a_q[0];
        b_d[0]     = b_q[0];
        sum_d[0]   = sum_q[0];
        carry_d[0] = carry_q[0];
        if (in_valid) begin
            a_d[0]              = A;
            b_d[0]              = b_in;
            sum_d[0]            = '0;
            sum_d[0][SEG_W-1:0] = seg_sum[0];
            carry_d[0]          = seg_cout[0];
        end

        // Data registers only load behind a valid beat, so outputs hold across bubbles.
        for (int unsigned k = 1; k < NSEG; k++) begin
            valid_d[k] = valid_q[k-1];
            a_d[k]     = a_q[k];
            b_d[k]     = b_q[k];
            sum_d[k]   = sum_q[k];
            carry_d[k] = carry_q[k];
            if (valid_q[k-1]) begin
                a_d[k]                     = a_q[k-1];
                b_d[k]                     = b_q[k-1];
                sum_d[k]                   = sum_q[k-1];
                sum_d[k][k*SEG_W +: SEG_W] = seg_sum[k];
                carry_d[k]                 = seg_cout[k];
            end
        end

        ovf_d  = ovf_q;
        zero_d = zero_q;
        if (valid_d[NSEG-1]) begin
            ovf_d  = seg_cmsb[NSEG-1] ^ seg_cout[NSEG-1];
            zero_d = (sum_d[NSEG-1] == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < NSEG; k++) begin
                valid_q[k] <= 1'b0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                sum_q[k]   <= '0;
                carry_q[k] <= 1'b0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (!stall) begin
            for (int unsigned k = 0; k < NSEG; k++) begin
                valid_q[k] <= valid_d[k];
                a_q[k]     <= a_d[k];
                b_q[k]     <= b_d[k];
                sum_q[k]   <= sum_d[k];
                carry_q[k] <= carry_d[k];
            end
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign in_ready  = !stall;
    assign out_valid = valid_q[NSEG-1];
    assign S         = sum_q[NSEG-1];
    assign Cout      = carry_q[NSEG-1];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_cla_pipelined_addsub.sv
// Bench for cla_pipelined_addsub: three configurations (16/4, 32/8, 64/16) share one stimulus
// stream and are each checked against an arithmetic reference model.
module tb_cla_pipelined_addsub;

    typedef struct packed {
        logic [63:0] s;
        logic        c;
        logic        o;
        logic        z;
    } exp_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        sb;
        exp_t        e32;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        Cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] A = '0;
    logic [63:0] B = '0;

    logic        ir16, ir32, ir64, ov16, ov32, ov64;
    logic        c16, c32, c64, o16, o32, o64, z16, z32, z64;
    logic [15:0] s16;
    logic [31:0] s32;
    logic [63:0] s64;

    logic        ir_w [3];
    logic        ov_w [3];
    logic        co_w [3];
    logic        of_w [3];
    logic        z_w  [3];
    logic [63:0] s_w  [3];

    int unsigned wid [3] = '{16, 32, 64};
    int          n_checks = 0;
    int          n_pass = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    exp_t        q2[$];

    always #5 clk = ~clk;

    cla_pipelined_addsub #(.WIDTH(16), .SEG_W(4)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir16), .A(A[15:0]), .B(B[15:0]),
        .Cin(Cin), .sub(sub), .out_valid(ov16), .out_ready(out_ready), .S(s16), .Cout(c16),
        .ovf(o16), .zero(z16)
    );

    cla_pipelined_addsub #(.WIDTH(32), .SEG_W(8)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir32), .A(A[31:0]), .B(B[31:0]),
        .Cin(Cin), .sub(sub), .out_valid(ov32), .out_ready(out_ready), .S(s32), .Cout(c32),
        .ovf(o32), .zero(z32)
    );

    cla_pipelined_addsub #(.WIDTH(64), .SEG_W(16)) u_dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir64), .A(A), .B(B),
        .Cin(Cin), .sub(sub), .out_valid(ov64), .out_ready(out_ready), .S(s64), .Cout(c64),
        .ovf(o64), .zero(z64)
    );

    always_comb begin
        ir_w[0] = ir16; ir_w[1] = ir32; ir_w[2] = ir64;
        ov_w[0] = ov16; ov_w[1] = ov32; ov_w[2] = ov64;
        co_w[0] = c16;  co_w[1] = c32;  co_w[2] = c64;
        of_w[0] = o16;  of_w[1] = o32;  of_w[2] = o64;
        z_w[0]  = z16;  z_w[1]  = z32;  z_w[2]  = z64;
        s_w[0]  = 64'(s16);
        s_w[1]  = 64'(s32);
        s_w[2]  = s64;
    end

    // Reference: w-bit A + (sub ? ~B : B) + Cin; signed overflow when like-signed operands give an unlike-signed sum.
    function automatic exp_t model(input int unsigned w, input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic sb);
        logic [63:0] mask;
        logic [63:0] am;
        logic [63:0] bm;
        logic [64:0] full;
        exp_t        e;
        mask   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        am     = a & mask;
        bm     = (sb ? ~b : b) & mask;
        full   = {1'b0, am} + {1'b0, bm} + 65'(cin);
        e.s    = full[63:0] & mask;
        e.c    = full[w];
        e.o    = (am[w-1] == bm[w-1]) && (e.s[w-1] != am[w-1]);
        e.z    = (e.s == 64'd0);
        return e;
    endfunction

    task automatic push_exp(input int i, input exp_t e);
        case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic pop_exp(input int i, output exp_t e, output bit ok);
        ok = 1'b1;
        e  = '0;
        case (i)
            0: if (q0.size() == 0) ok = 1'b0; else e = q0.pop_front();
            1: if (q1.size() == 0) ok = 1'b0; else e = q1.pop_front();
            default: if (q2.size() == 0) ok = 1'b0; else e = q2.pop_front();
        endcase
    endtask

    // Present one beat with out_ready=1, report acceptance, edge count to out_valid, the result and the post-drain state.
    task automatic send_single(input logic [63:0] a, input logic [63:0] b, input logic cin, input logic sb,
                               output logic acc, output int lat, output exp_t got [3],
                               output logic [63:0] s_hold, output logic ov_after);
        A = a; B = b; Cin = cin; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        acc = ir_w[0] & ir_w[1] & ir_w[2];
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!ov_w[1] && lat < 16) begin
            @(posedge clk); #1;
            lat++;
        end
        for (int i = 0; i < 3; i++) got[i] = {s_w[i], co_w[i], of_w[i], z_w[i]};
        @(posedge clk); #1;
        s_hold   = s_w[1];
        ov_after = ov_w[0] | ov_w[1] | ov_w[2];
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        A = {$urandom, $urandom}; B = {$urandom, $urandom}; Cin = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({ov_w[i], s_w[i], co_w[i], of_w[i], z_w[i]} !== 68'd0)
                $display("FAIL reset_state[%0d]: got v=%b S=%h C=%b o=%b z=%b expected all zero",
                         i, ov_w[i], s_w[i], co_w[i], of_w[i], z_w[i]);
            else n_pass++;
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (ir_w[i] !== 1'b1 || ov_w[i] !== 1'b0)
                $display("FAIL reset_release[%0d]: got in_ready=%b out_valid=%b expected 1/0", i, ir_w[i], ov_w[i]);
            else n_pass++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_add;
        vec_t        v [2];
        logic        acc, ova;
        int          lat;
        exp_t        got [3];
        exp_t        e;
        logic [63:0] sh;
        v[0] = '{a: 64'hFFFF_FFFF, b: 64'h1, cin: 1'b0, sb: 1'b0,
                 e32: '{s: 64'h0, c: 1'b1, o: 1'b0, z: 1'b1}};
        v[1] = '{a: 64'h7FFF_FFFF, b: 64'h1, cin: 1'b0, sb: 1'b0,
                 e32: '{s: 64'h8000_0000, c: 1'b0, o: 1'b1, z: 1'b0}};
        for (int n = 0; n < 2; n++) begin
            send_single(v[n].a, v[n].b, v[n].cin, v[n].sb, acc, lat, got, sh, ova);
            n_checks++;
            if (acc !== 1'b1 || lat != 3) $display("FAIL add_timing[%0d]: got acc=%b latency=%0d expected 1/3", n, acc, lat);
            else n_pass++;
            n_checks++;
            if (got[1] !== v[n].e32) $display("FAIL add32[%0d]: got %h expected %h", n, got[1], v[n].e32);
            else n_pass++;
            for (int i = 0; i < 3; i += 2) begin
                e = model(wid[i], v[n].a, v[n].b, v[n].cin, v[n].sb);
                n_checks++;
                if (got[i] !== e) $display("FAIL add_w%0d[%0d]: got %h expected %h", wid[i], n, got[i], e);
                else n_pass++;
            end
            n_checks++;
            if (ova !== 1'b0 || sh !== v[n].e32.s)
                $display("FAIL add_hold[%0d]: got out_valid=%b S=%h expected 0/%h", n, ova, sh, v[n].e32.s);
            else n_pass++;
        end
    endtask

    task automatic test_sub;
        vec_t        v [2];
        logic        acc, ova;
        int          lat;
        exp_t        got [3];
        exp_t        e;
        logic [63:0] sh;
        v[0] = '{a: 64'h5, b: 64'h7, cin: 1'b1, sb: 1'b1,
                 e32: '{s: 64'hFFFF_FFFE, c: 1'b0, o: 1'b0, z: 1'b0}};
        v[1] = '{a: 64'h8000_0000, b: 64'h1, cin: 1'b1, sb: 1'b1,
                 e32: '{s: 64'h7FFF_FFFF, c: 1'b1, o: 1'b1, z: 1'b0}};
        for (int n = 0; n < 2; n++) begin
            send_single(v[n].a, v[n].b, v[n].cin, v[n].sb, acc, lat, got, sh, ova);
            n_checks++;
            if (acc !== 1'b1 || lat != 3) $display("FAIL sub_timing[%0d]: got acc=%b latency=%0d expected 1/3", n, acc, lat);
            else n_pass++;
            n_checks++;
            if (got[1] !== v[n].e32) $display("FAIL sub32[%0d]: got %h expected %h", n, got[1], v[n].e32);
            else n_pass++;
            for (int i = 0; i < 3; i += 2) begin
                e = model(wid[i], v[n].a, v[n].b, v[n].cin, v[n].sb);
                n_checks++;
                if (got[i] !== e) $display("FAIL sub_w%0d[%0d]: got %h expected %h", wid[i], n, got[i], e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_midflight;
        logic        acc, ova;
        int          lat;
        exp_t        got [3];
        exp_t        e;
        logic [63:0] sh;
        logic [63:0] a, b;
        out_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            in_valid = 1'b1; A = {$urandom, $urandom}; B = {$urandom, $urandom}; Cin = 1'b0; sub = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        send_single(a, b, 1'b1, 1'b1, acc, lat, got, sh, ova);
        n_checks++;
        if (acc !== 1'b1 || lat != 3)
            $display("FAIL flush_timing: got acc=%b latency=%0d expected 1/3", acc, lat);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            e = model(wid[i], a, b, 1'b1, 1'b1);
            n_checks++;
            if (got[i] !== e) $display("FAIL flush_result_w%0d: got %h expected %h", wid[i], got[i], e);
            else n_pass++;
        end
        n_checks++;
        if (ova !== 1'b0) $display("FAIL flush_extra: got out_valid=%b expected 0", ova);
        else n_pass++;
    endtask

    // pattern_mode: in_valid held high, out_ready cycles 1-0-0-1; otherwise both randomised.
    task automatic run_stream(input int unsigned n, input bit pattern_mode, input string name);
        int unsigned sent = 0;
        int unsigned cyc = 0;
        int unsigned budget = n * 8 + 200;
        exp_t        e;
        bit          ok;
        while ((sent < n || q0.size() != 0 || q1.size() != 0 || q2.size() != 0) && cyc < budget) begin
            if (sent < n) begin
                in_valid = pattern_mode ? 1'b1 : ($urandom_range(0, 3) != 0);
                A = {$urandom, $urandom};
                B = {$urandom, $urandom};
                case ($urandom_range(0, 7))
                    0: B = A;
                    1: B = ~A;
                    default: ;
                endcase
                Cin = 1'($urandom_range(0, 1));
                sub = 1'($urandom_range(0, 1));
            end else begin
                in_valid = 1'b0;
            end
            out_ready = pattern_mode ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : ($urandom_range(0, 3) != 0);
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (ir_w[i] !== !(ov_w[i] && !out_ready))
                    $display("FAIL %s_in_ready_w%0d: got %b expected %b at cycle %0d",
                             name, wid[i], ir_w[i], !(ov_w[i] && !out_ready), cyc);
                else n_pass++;
                if (ov_w[i] && out_ready) begin
                    pop_exp(i, e, ok);
                    n_checks++;
                    if (!ok)
                        $display("FAIL %s_extra_w%0d: got unexpected result %h expected none", name, wid[i], s_w[i]);
                    else if ({s_w[i], co_w[i], of_w[i], z_w[i]} !== e)
                        $display("FAIL %s_result_w%0d: got %h expected %h", name, wid[i],
                                 {s_w[i], co_w[i], of_w[i], z_w[i]}, e);
                    else n_pass++;
                end
                if (in_valid && ir_w[i]) push_exp(i, model(wid[i], A, B, Cin, sub));
            end
            if (in_valid && ir_w[1]) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (sent < n || q0.size() != 0 || q1.size() != 0 || q2.size() != 0)
            $display("FAIL %s_drain: got sent=%0d pending=%0d/%0d/%0d expected sent=%0d pending 0",
                     name, sent, q0.size(), q1.size(), q2.size(), n);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        run_stream(16, 1'b1, "backpressure");
    endtask

    task automatic test_random;
        run_stream(10000, 1'b0, "random");
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
